mod12_display_driver: RTL and testbench

//  Downstream consumer of the mod-12 up/down counter. Samples the 4-bit count (0..11) and direction.

---
 rtl/mod12_pkg.sv | 31 +++
 rtl/mod12_display_driver_seg7_decoder.sv | 12 +
 rtl/mod12_display_driver.sv | 104 ++++++++++
 tb/tb_mod12_display_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mod12_pkg.sv
// Shared types and constants for the mod-12 counter display path: segment
// encodings (active-low {g,f,e,d,c,b,a}) and the terminal count of the counter.
package mod12_pkg;

  localparam int MOD12_MAX = 11;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'h3F;

  // Active-low digit table for decimal 0..9; anything else falls back to a dash.
  function automatic seg7_t seg7_lookup(input logic [3:0] d);
    seg7_t s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mod12_display_driver_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; codes above 9
// render as a dash.
module seg7_decoder
  import mod12_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  assign seg = (bcd > 4'd9) ? SEG_DASH : seg7_lookup(bcd);

endmodule

// File: rtl/mod12_display_driver.sv
// Consumer of a mod-12 up/down counter: cascade carry/borrow pulses, range
// error flag and a 2-digit multiplexed decimal display.
// Build option MOD12_DISP_HOUR12_EN shows v+1 (1..12) instead of v (0..11).
module mod12_display_driver
  import mod12_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int MAX_VAL = MOD12_MAX,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  input  logic             up_dn,
  output seg7_t            seg_o,
  output logic [1:0]       an_o,
  output logic             carry_o,
  output logic             borrow_o,
  output logic             err_o
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int VAL_W = CNT_W + 1;

  // count_in/up_dn carry no handshake: they are sampled on every clock edge.
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] prev_q;
  logic             dir_q;
  logic             cnt_vld;
  logic             prev_vld;
  logic [PRE_W-1:0] prescaler;
  logic             digit_sel;

  logic             err_now;
  logic [VAL_W-1:0] disp_val;
  logic             tens;
  logic [3:0]       units;
  logic [3:0]       digit_bcd;
  logic             blank_tens;
  seg7_t            dec_seg;
  seg7_t            seg_next;

  always_comb begin
    err_now = cnt_q > CNT_W'(MAX_VAL);
`ifdef MOD12_DISP_HOUR12_EN
    disp_val = {1'b0, cnt_q} + VAL_W'(1);
`else
    disp_val = {1'b0, cnt_q};
`endif
    tens       = disp_val >= VAL_W'(10);
    units      = 4'(disp_val - (tens ? VAL_W'(10) : VAL_W'(0)));
    // Forcing an out-of-range code makes the decoder emit the dash on both digits.
    digit_bcd  = err_now ? 4'hF : (digit_sel ? {3'b000, tens} : units);
    blank_tens = digit_sel & ~tens & ~err_now;
    seg_next   = blank_tens ? SEG_BLANK : dec_seg;
  end

  seg7_decoder u_dec (
    .bcd (digit_bcd),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      prev_q    <= '0;
      dir_q     <= 1'b0;
      cnt_vld   <= 1'b0;
      prev_vld  <= 1'b0;
      prescaler <= '0;
      digit_sel <= 1'b0;
      seg_o     <= SEG_BLANK;
      an_o      <= 2'b11;
      carry_o   <= 1'b0;
      borrow_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      cnt_q    <= count_in;
      dir_q    <= up_dn;
      prev_q   <= cnt_q;
      cnt_vld  <= 1'b1;
      // prev_q only holds a real sample once two post-reset samples exist.
      prev_vld <= cnt_vld;

      carry_o  <= prev_vld & dir_q & (prev_q == CNT_W'(MAX_VAL)) &
                  (cnt_q == '0) & ~err_o;
      borrow_o <= prev_vld & ~dir_q & (prev_q == '0) &
                  (cnt_q == CNT_W'(MAX_VAL)) & ~err_o;
      err_o    <= err_now;

      if (prescaler == PRE_W'(CLK_DIV - 1)) begin
        prescaler <= '0;
        digit_sel <= ~digit_sel;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      // Segments and anodes update on the same edge so no digit ghosts.
      seg_o <= seg_next;
      an_o  <= digit_sel ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: tb/tb_mod12_display_driver.sv
// Directed-vector bench for mod12_display_driver: a driver pushes the expected
// post-edge outputs for each vector into exp_q; a monitor pops and compares.
module tb_mod12_display_driver;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       up_dn;
  logic [6:0] seg_o;
  logic [1:0] an_o;
  logic       carry_o;
  logic       borrow_o;
  logic       err_o;

  mod12_display_driver #(.CLK_DIV(D), .MAX_VAL(11), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .up_dn    (up_dn),
    .seg_o    (seg_o),
    .an_o     (an_o),
    .carry_o  (carry_o),
    .borrow_o (borrow_o),
    .err_o    (err_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct packed {
    logic       rst;
    logic [3:0] cin;
    logic       dn;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic add(input logic r, input int v, input logic d, input int n);
    vec_t t;
    t.rst = r;
    t.cin = 4'(v);
    t.dn  = d;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // History view: what each register held just before edge k.
  function automatic bit is_rst(input int i);
    if (i < 0) return 1'b1;
    return vecs[i].rst;
  endfunction

  function automatic int cnt_b(input int k);
    if (is_rst(k - 1)) return 0;
    return int'(vecs[k-1].cin);
  endfunction

  function automatic int prev_b(input int k);
    if (is_rst(k - 1)) return 0;
    return cnt_b(k - 1);
  endfunction

  function automatic bit err_b(input int k);
    if (is_rst(k - 1)) return 1'b0;
    return cnt_b(k - 1) > 11;
  endfunction

  function automatic int run_b(input int k);
    int n = 0;
    for (int j = k - 1; j >= 0; j--) begin
      if (vecs[j].rst) break;
      n++;
    end
    return n;
  endfunction

  // Expected {seg, an, carry, borrow, err} right after edge k.
  function automatic logic [11:0] expected(input int k);
    int   c, p, v, units;
    bit   pv, dir, eb, carry, borrow, err, sel, tens;
    logic [6:0] seg;
    logic [1:0] an;
    if (vecs[k].rst) return {7'h7F, 2'b11, 3'b000};
    c   = cnt_b(k);
    p   = prev_b(k);
    pv  = !is_rst(k - 1) && !is_rst(k - 2);
    dir = is_rst(k - 1) ? 1'b0 : vecs[k-1].dn;
    eb  = err_b(k);
    carry  = pv && dir && p == 11 && c == 0 && !eb;
    borrow = pv && !dir && p == 0 && c == 11 && !eb;
    err    = c > 11;
    sel    = ((run_b(k) / D) % 2) == 1;
    an     = sel ? 2'b01 : 2'b10;
`ifdef MOD12_DISP_HOUR12_EN
    v = c + 1;
`else
    v = c;
`endif
    tens  = v >= 10;
    units = tens ? v - 10 : v;
    if (err)      seg = 7'h3F;
    else if (sel) seg = tens ? seg_of(1) : 7'h7F;
    else          seg = seg_of(units);
    return {seg, an, carry, borrow, err};
  endfunction

  // ---------------- driver ----------------
  initial begin
    reset    = 1'b1;
    count_in = 4'd7;
    up_dn    = 1'b1;

    add(1, 7, 1, 3);                                      // reset held, then show 7
    add(0, 7, 1, 10);
    add(0, 10, 1, 1); add(0, 11, 1, 1); add(0, 0, 1, 1); add(0, 1, 1, 4);  // carry
    add(0, 1, 0, 1);  add(0, 0, 0, 1);  add(0, 11, 0, 1); add(0, 10, 0, 4); // borrow
    add(0, 14, 1, 6); add(0, 11, 1, 1); add(0, 0, 1, 4);  // error, dashes
    add(0, 5, 1, 2);  add(0, 0, 1, 3);                    // non-wrap jump
    add(0, 11, 0, 1); add(0, 0, 0, 3);                    // 11->0 counting down
    add(0, 0, 1, 1);  add(0, 11, 1, 3);                   // 0->11 counting up
    add(0, 11, 1, 9);                                     // 11 on both digits
    add(1, 11, 1, 2); add(0, 0, 1, 5);                    // reset mid-scan, prev=11
    for (int v = 0; v <= 11; v++) add(0, v, 1, 8);
    add(0, 0, 1, 2);
    for (int v = 11; v >= 0; v--) add(0, v, 0, 8);
    add(0, 11, 0, 2); add(0, 15, 0, 3); add(0, 12, 1, 2); add(0, 9, 1, 8);

    for (int k = 0; k < vecs.size(); k++) begin
      reset    = vecs[k].rst;
      count_in = vecs[k].cin;
      up_dn    = vecs[k].dn;
      exp_q.push_back(expected(k));
      @(negedge clk);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [11:0] want;
    logic [11:0] got;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {seg_o, an_o, carry_o, borrow_o, err_o};
      if (got !== want) begin
        n_fail++;
        $display("FAIL vec %0d: got seg=%h an=%b c=%b b=%b e=%b, required seg=%h an=%b c=%b b=%b e=%b",
                 n_vec, got[11:5], got[4:3], got[2], got[1], got[0],
                 want[11:5], want[4:3], want[2], want[1], want[0]);
      end
      n_vec++;
    end
  end

endmodule
